// File: rtl/syn_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// overflow/underflow pulses and optional first-word-fall-through read.
// Ports:
//   clk, rst (sync, active-high)
//   data_in, write_en, read_en
//   data_out, full, empty, almost_full, almost_empty, count
//   overflow, underflow
module syn_fifo_flags #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AF_TH = 12,
  parameter int AE_TH = 4,
  parameter int FWFT  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     write_en,
  input  logic                     read_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_ok, rd_ok;

  // Flags come from the count register only.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_TH));
  assign almost_empty = (count_q <= CW'(AE_TH));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // A write into a full FIFO is fine when a read frees a slot
  // in the same cycle.
  assign wr_ok = write_en & (~full | read_en);
  assign rd_ok = read_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
    ovf_d   = write_en & full & ~read_en;
    unf_d   = read_en & empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is not reset; pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem_q[wr_ptr_q] <= data_in;
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out = mem_q[rd_ptr_q];
  end else begin : g_std
    logic [WIDTH-1:0] dout_q, dout_d;

    // Same-entry read+write when full reads the old word, since
    // the memory write lands at the same edge.
    always_comb begin
      dout_d = dout_q;
      if (rd_ok) dout_d = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
      if (rst) dout_q <= '0;
      else     dout_q <= dout_d;
    end

    assign data_out = dout_q;
  end

endmodule
